// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and IF/ID boundary bundle for fetch_unit
interface fetch_unit_if #(
   parameter int WORD_LENGTH   = 16,
   parameter int ADDRESS_SPACE = 21
);
   logic [ADDRESS_SPACE-1:0] MAR;
   logic [WORD_LENGTH-1:0]   MDR;
   logic                     stall;
   logic                     redirect_valid;
   logic [ADDRESS_SPACE-1:0] redirect_pc;
   logic                     if_id_valid;
   logic [2*WORD_LENGTH-1:0] if_id_instr;
   logic [ADDRESS_SPACE-1:0] if_id_pc;
   logic [ADDRESS_SPACE-1:0] if_id_pc_next;

   modport master (
      output MAR, if_id_valid, if_id_instr, if_id_pc, if_id_pc_next,
      input  MDR, stall, redirect_valid, redirect_pc
   );

   modport slave (
      input  MAR, if_id_valid, if_id_instr, if_id_pc, if_id_pc_next,
      output MDR, stall, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: boot vector load, PC, 1/2-word assembly
// Handles stall and branch redirect; redirect outranks stall.
module fetch_unit #(
   parameter int WORD_LENGTH   = 16,
   parameter int ADDRESS_SPACE = 21,
   parameter int LONG_BIT      = 15
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam logic [1:0] BOOT0  = 2'd0;
   localparam logic [1:0] BOOT1  = 2'd1;
   localparam logic [1:0] FETCH1 = 2'd2;
   localparam logic [1:0] FETCH2 = 2'd3;

   logic [1:0]               state;
   logic [ADDRESS_SPACE-1:0] pc;
   logic [ADDRESS_SPACE-1:0] pc_inc;
   logic [4:0]               vec_hi;
   logic [WORD_LENGTH-1:0]   first_word;
   logic [ADDRESS_SPACE-1:0] first_pc;

   assign pc_inc = pc + ADDRESS_SPACE'(1);

   always_comb begin
      case (state)
         BOOT0:   bus.MAR = '0;
         BOOT1:   bus.MAR = ADDRESS_SPACE'(1);
         default: bus.MAR = pc;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= BOOT0;
         pc                <= '0;
         vec_hi            <= '0;
         first_word        <= '0;
         first_pc          <= '0;
         bus.if_id_valid   <= 1'b0;
         bus.if_id_instr   <= '0;
         bus.if_id_pc      <= '0;
         bus.if_id_pc_next <= '0;
      end else begin
         case (state)
            BOOT0: begin
               vec_hi <= bus.MDR[4:0];
               state  <= BOOT1;
            end
            BOOT1: begin
               // boot vector is {M[0][4:0], M[1]} fitted to the address width
               pc    <= ADDRESS_SPACE'({vec_hi, bus.MDR});
               state <= FETCH1;
            end
            FETCH1: begin
               if (bus.redirect_valid) begin
                  pc              <= bus.redirect_pc;
                  bus.if_id_valid <= 1'b0;
               end else if (!bus.stall) begin
                  pc <= pc_inc;
                  if (bus.MDR[LONG_BIT]) begin
                     first_word      <= bus.MDR;
                     first_pc        <= pc;
                     bus.if_id_valid <= 1'b0;
                     state           <= FETCH2;
                  end else begin
                     bus.if_id_instr   <= {bus.MDR, {WORD_LENGTH{1'b0}}};
                     bus.if_id_pc      <= pc;
                     bus.if_id_pc_next <= pc_inc;
                     bus.if_id_valid   <= 1'b1;
                  end
               end
            end
            default: begin
               // FETCH2: a redirect drops the half-assembled instruction
               if (bus.redirect_valid) begin
                  pc              <= bus.redirect_pc;
                  bus.if_id_valid <= 1'b0;
                  state           <= FETCH1;
               end else if (!bus.stall) begin
                  bus.if_id_instr   <= {first_word, bus.MDR};
                  bus.if_id_pc      <= first_pc;
                  bus.if_id_pc_next <= pc_inc;
                  bus.if_id_valid   <= 1'b1;
                  pc                <= pc_inc;
                  state             <= FETCH1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with sparse memory model
module tb_fetch_unit;
   localparam int WL = 16;
   localparam int AS = 21;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.WORD_LENGTH(WL), .ADDRESS_SPACE(AS)) bus ();
   fetch_unit #(.WORD_LENGTH(WL), .ADDRESS_SPACE(AS), .LONG_BIT(15)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   logic [15:0] mem [int unsigned];
   logic [15:0] seed = 16'h0;
   int          mem_gen = 0;
   int          checks = 0;
   int          errors = 0;

   // unwritten locations return a scrambled function of the address
   function automatic logic [15:0] rd(input logic [20:0] a);
      logic [31:0] h;
      if (mem.exists(32'(a))) return mem[32'(a)];
      h = {11'd0, a} * 32'h9E3779B1;
      return h[28:13] ^ seed;
   endfunction

   always @(bus.MAR or mem_gen) bus.MDR = rd(bus.MAR);

   wire [95:0] obs = {bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, bus.if_id_pc_next, bus.MAR};

   task automatic wr(input logic [20:0] a, input logic [15:0] d);
      mem[32'(a)] = d;
      mem_gen++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem;
      mem.delete();
      seed = 16'h0;
      mem_gen++;
   endtask

   task automatic boot_release;
      reset = 1'b0;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      tick;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      tick;
      checks++;
      if (obs !== 96'h0) begin
         errors++;
         $display("FAIL reset_state: got %h exp %h", obs, 96'h0);
      end
   endtask

   task automatic test_boot;
      clear_mem;
      wr(0, 16'h0000); wr(1, 16'h0010); wr(21'h10, 16'h1234);
      boot_release;
      checks++;
      if (bus.MAR !== 21'h0) begin errors++; $display("FAIL boot_mar0: got %h exp 0", bus.MAR); end
      tick;
      checks++;
      if (bus.MAR !== 21'h1) begin errors++; $display("FAIL boot_mar1: got %h exp 1", bus.MAR); end
      tick;
      checks++;
      if (obs !== {1'b0, 32'h0, 21'h0, 21'h0, 21'h10}) begin
         errors++; $display("FAIL boot_mar_pc: got %h", obs);
      end
      tick;
      checks++;
      if (obs !== {1'b1, 32'h12340000, 21'h10, 21'h11, 21'h11}) begin
         errors++; $display("FAIL boot_first_instr: got %h exp %h", obs, {1'b1, 32'h12340000, 21'h10, 21'h11, 21'h11});
      end
   endtask

   task automatic test_long;
      clear_mem;
      wr(0, 16'h0000); wr(1, 16'h0010); wr(21'h10, 16'h8005); wr(21'h11, 16'hBEEF);
      boot_release;
      tick; tick; tick;
      checks++;
      if (obs !== {1'b0, 32'h0, 21'h0, 21'h0, 21'h11}) begin
         errors++; $display("FAIL long_bubble: got %h", obs);
      end
      tick;
      checks++;
      if (obs !== {1'b1, 32'h8005BEEF, 21'h10, 21'h12, 21'h12}) begin
         errors++; $display("FAIL long_instr: got %h exp %h", obs, {1'b1, 32'h8005BEEF, 21'h10, 21'h12, 21'h12});
      end
   endtask

   task automatic test_stall;
      clear_mem;
      wr(0, 16'h0000); wr(1, 16'h0010);
      wr(21'h10, 16'h1234); wr(21'h11, 16'h2222); wr(21'h12, 16'h3333);
      boot_release;
      tick; tick; tick;
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (obs !== {1'b1, 32'h12340000, 21'h10, 21'h11, 21'h11}) begin
            errors++; $display("FAIL stall_hold[%0d]: got %h", i, obs);
         end
      end
      bus.stall = 1'b0;
      tick;
      checks++;
      if (obs !== {1'b1, 32'h22220000, 21'h11, 21'h12, 21'h12}) begin
         errors++; $display("FAIL stall_release1: got %h", obs);
      end
      tick;
      checks++;
      if (obs !== {1'b1, 32'h33330000, 21'h12, 21'h13, 21'h13}) begin
         errors++; $display("FAIL stall_release2: got %h", obs);
      end
   endtask

   task automatic test_redirect_fetch2;
      clear_mem;
      wr(0, 16'h0000); wr(1, 16'h0010);
      wr(21'h10, 16'h8005); wr(21'h11, 16'hBEEF); wr(21'h40, 16'h0042);
      boot_release;
      tick; tick; tick;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 21'h40;
      tick;
      bus.redirect_valid = 1'b0;
      checks++;
      if (obs !== {1'b0, 32'h0, 21'h0, 21'h0, 21'h40}) begin
         errors++; $display("FAIL redir_drop: got %h", obs);
      end
      tick;
      checks++;
      if (obs !== {1'b1, 32'h00420000, 21'h40, 21'h41, 21'h41}) begin
         errors++; $display("FAIL redir_target: got %h", obs);
      end
   endtask

   task automatic test_wrap_priority;
      clear_mem;
      wr(0, 16'h001F); wr(1, 16'hFFFF); wr(21'h1FFFFF, 16'h0777); wr(21'h20, 16'h0120);
      boot_release;
      tick; tick; tick;
      checks++;
      if (obs !== {1'b1, 32'h07770000, 21'h1FFFFF, 21'h0, 21'h0}) begin
         errors++; $display("FAIL wrap_pc_next: got %h", obs);
      end
      bus.stall = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 21'h20;
      tick;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++;
      if (obs !== {1'b0, 32'h07770000, 21'h1FFFFF, 21'h0, 21'h20}) begin
         errors++; $display("FAIL prio_redirect: got %h", obs);
      end
      tick;
      checks++;
      if (obs !== {1'b1, 32'h01200000, 21'h20, 21'h21, 21'h21}) begin
         errors++; $display("FAIL prio_target: got %h", obs);
      end
   endtask

   task automatic test_reset_mid_long;
      clear_mem;
      wr(0, 16'h0000); wr(1, 16'h0010);
      wr(21'h10, 16'h0100); wr(21'h11, 16'h8005); wr(21'h12, 16'hBEEF);
      boot_release;
      tick; tick; tick; tick;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs !== 96'h0) begin errors++; $display("FAIL async_reset: got %h exp 0", obs); end
      tick; tick;
      reset = 1'b1;
      checks++;
      if (bus.MAR !== 21'h0) begin errors++; $display("FAIL reboot_mar0: got %h", bus.MAR); end
      tick; tick; tick;
      checks++;
      if (obs !== {1'b1, 32'h01000000, 21'h10, 21'h11, 21'h11}) begin
         errors++; $display("FAIL reboot_instr: got %h", obs);
      end
   endtask

   // transaction-level model: walk the program from the expected start address
   task automatic test_random;
      logic [15:0] m0, m1, w0;
      logic [20:0] walk, rp;
      logic [95:0] prev, expv;
      logic        half, st, rv;
      clear_mem;
      seed = 16'($urandom);
      m0 = 16'($urandom);
      m1 = 16'($urandom);
      wr(0, m0); wr(1, m1);
      boot_release;
      bus.stall = 1'($urandom);
      bus.redirect_valid = 1'($urandom);
      bus.redirect_pc = 21'($urandom);
      tick;
      checks++;
      if (bus.MAR !== 21'h1) begin errors++; $display("FAIL rand_boot1: got %h", bus.MAR); end
      bus.stall = 1'($urandom);
      bus.redirect_valid = 1'($urandom);
      tick;
      walk = {m0[4:0], m1};
      checks++;
      if (bus.MAR !== walk) begin errors++; $display("FAIL rand_boot_pc: got %h exp %h", bus.MAR, walk); end
      half = 1'b0;
      for (int c = 0; c < 800; c++) begin
         st = ($urandom % 4) == 0;
         rv = ($urandom % 12) == 0;
         rp = 21'($urandom);
         bus.stall = st;
         bus.redirect_valid = rv;
         bus.redirect_pc = rp;
         prev = obs;
         tick;
         checks++;
         if (rv) begin
            if (bus.if_id_valid !== 1'b0 || bus.MAR !== rp) begin
               errors++; $display("FAIL rand_redirect[%0d]: valid %b mar %h exp mar %h", c, bus.if_id_valid, bus.MAR, rp);
            end
            walk = rp;
            half = 1'b0;
         end else if (st) begin
            if (obs !== prev) begin
               errors++; $display("FAIL rand_stall[%0d]: got %h exp %h", c, obs, prev);
            end
         end else begin
            w0 = rd(walk);
            if (!bus.if_id_valid) begin
               if (!w0[15] || half || bus.MAR !== walk + 21'd1) begin
                  errors++; $display("FAIL rand_bubble[%0d]: mar %h walk %h", c, bus.MAR, walk);
               end
               half = 1'b1;
            end else begin
               if (w0[15])
                  expv = {1'b1, w0, rd(walk + 21'd1), walk, walk + 21'd2, walk + 21'd2};
               else
                  expv = {1'b1, w0, 16'h0, walk, walk + 21'd1, walk + 21'd1};
               if (obs !== expv || (w0[15] && !half)) begin
                  errors++; $display("FAIL rand_instr[%0d]: got %h exp %h", c, obs, expv);
               end
               walk = w0[15] ? walk + 21'd2 : walk + 21'd1;
               half = 1'b0;
            end
         end
      end
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      mem_gen++;
      test_reset;
      test_boot;
      test_long;
      test_stall;
      test_redirect_fetch2;
      test_wrap_priority;
      test_reset_mid_long;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
